// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART register map, bit indices and read-source codes
package uart_pkg;

    // Word index (byte address [3:2]) of each register
    localparam logic [1:0] UART_STATUS = 2'd0;
    localparam logic [1:0] UART_TX     = 2'd1;
    localparam logic [1:0] UART_RX     = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int ST_TX_FULL   = 0;
    localparam int ST_RX_AVAIL  = 1;
    localparam int ST_TX_OVF    = 2;
    localparam int ST_RX_UNF    = 3;

    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_RX_IE   = 1;
    localparam int CTRL_TX_IE   = 2;
    localparam int CTRL_CLR_OVF = 8;
    localparam int CTRL_CLR_UNF = 9;

    localparam int RX_VALID_BIT = 8;

    typedef enum logic [1:0] {
        SRC_STATUS = 2'd0,
        SRC_RX     = 2'd1,
        SRC_CTRL   = 2'd2,
        SRC_ZERO   = 2'd3
    } rd_src_e;

endpackage

// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - CPU load/store bridge to the UART TX/RX FIFOs with status, control and irq
module uart_mmio
    import uart_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              tx_fifo_wr_en,
    output logic [7:0]        tx_fifo_din,
    input  logic              tx_fifo_full,
    output logic              rx_fifo_rd_en,
    input  logic [7:0]        rx_fifo_dout,
    input  logic              rx_fifo_empty,
    output logic              start_tx,
    output logic              irq
);

    logic              tx_en, rx_ie, tx_ie;
    logic              tx_ovf, rx_unf;
    logic              pend_valid;
    rd_src_e           pend_src;
    logic [DATA_W-1:0] snap_q;
    logic [DATA_W-1:0] last_q;

    logic [1:0]        word;
    logic              mapped, acc;
    logic              wr_tx, rd_rx, wr_ctrl;
    logic              ovf_set, unf_set;
    logic [DATA_W-1:0] status_word, ctrl_word;
    rd_src_e           next_src;
    logic [DATA_W-1:0] next_snap;
    logic              unused_bits;

    assign word   = req_addr[3:2];
    assign mapped = (req_addr >> 4) == '0;
    // Reset gates every strobe so an access issued under reset has no effect
    assign acc    = !rst && req_valid && mapped;

    assign wr_tx   = acc &&  req_we && (word == UART_TX);
    assign rd_rx   = acc && !req_we && (word == UART_RX);
    assign wr_ctrl = acc &&  req_we && (word == UART_CTRL);

    assign tx_fifo_wr_en = wr_tx && !tx_fifo_full;
    assign tx_fifo_din   = req_wdata[7:0];
    assign rx_fifo_rd_en = rd_rx && !rx_fifo_empty;

    assign ovf_set = wr_tx && tx_fifo_full;
    assign unf_set = rd_rx && rx_fifo_empty;

    assign status_word = DATA_W'({rx_unf, tx_ovf, !rx_fifo_empty, tx_fifo_full});
    assign ctrl_word   = DATA_W'({tx_ie, rx_ie, tx_en});

    always_comb begin
        next_src  = SRC_ZERO;
        next_snap = '0;
        case (word)
            UART_STATUS: begin
                next_src  = SRC_STATUS;
                next_snap = status_word;
            end
            UART_RX:     next_src = rx_fifo_empty ? SRC_ZERO : SRC_RX;
            UART_CTRL: begin
                next_src  = SRC_CTRL;
                next_snap = ctrl_word;
            end
            default:     next_src = SRC_ZERO;
        endcase
    end

    // RX data arrives from the FIFO in the response cycle, so it bypasses the snapshot
    always_comb begin
        rsp_rdata = last_q;
        if (pend_valid) begin
            case (pend_src)
                SRC_RX:  rsp_rdata = DATA_W'({1'b1, rx_fifo_dout});
                SRC_ZERO: rsp_rdata = '0;
                default: rsp_rdata = snap_q;
            endcase
        end
    end

    assign rsp_valid = pend_valid;
    assign start_tx  = tx_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid <= 1'b0;
            pend_src   <= SRC_ZERO;
            snap_q     <= '0;
            last_q     <= '0;
            tx_en      <= 1'b0;
            rx_ie      <= 1'b0;
            tx_ie      <= 1'b0;
            tx_ovf     <= 1'b0;
            rx_unf     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            pend_valid <= acc && !req_we;
            if (acc && !req_we) begin
                pend_src <= next_src;
                snap_q   <= next_snap;
            end
            if (pend_valid) begin
                last_q <= rsp_rdata;
            end
            if (wr_ctrl) begin
                tx_en <= req_wdata[CTRL_TX_EN];
                rx_ie <= req_wdata[CTRL_RX_IE];
                tx_ie <= req_wdata[CTRL_TX_IE];
            end
            // A new error event in the same cycle as its W1C keeps the flag set
            tx_ovf <= ovf_set || (tx_ovf && !(wr_ctrl && req_wdata[CTRL_CLR_OVF]));
            rx_unf <= unf_set || (rx_unf && !(wr_ctrl && req_wdata[CTRL_CLR_UNF]));
            irq    <= (rx_ie && !rx_fifo_empty) || (tx_ie && !tx_fifo_full) || tx_ovf || rx_unf;
        end
    end

    assign unused_bits = &{1'b0, req_addr[1:0], req_wdata[DATA_W-1:10]};

endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - directed self-checking bench for uart_mmio
module tb_uart_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        tx_fifo_wr_en;
    logic [7:0]  tx_fifo_din;
    logic        tx_fifo_full;
    logic        rx_fifo_rd_en;
    logic [7:0]  rx_fifo_dout = 8'h00;
    logic        rx_fifo_empty;
    logic        start_tx, irq;

    int checks = 0;
    int failures = 0;
    int tx_pulses = 0;
    int rd_pulses = 0;

    logic [7:0] rx_mem [0:15];
    logic [3:0] rx_wr = 4'd0;
    logic [3:0] rx_rd = 4'd0;

    always #5 clk = ~clk;

    uart_mmio #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .tx_fifo_wr_en(tx_fifo_wr_en), .tx_fifo_din(tx_fifo_din), .tx_fifo_full(tx_fifo_full),
        .rx_fifo_rd_en(rx_fifo_rd_en), .rx_fifo_dout(rx_fifo_dout), .rx_fifo_empty(rx_fifo_empty),
        .start_tx(start_tx), .irq(irq)
    );

    assign rx_fifo_empty = (rx_rd == rx_wr);

    always @(posedge clk) begin
        if (rx_fifo_rd_en) begin
            rx_fifo_dout <= rx_mem[rx_rd];
            rx_rd <= rx_rd + 4'd1;
        end
        if (tx_fifo_wr_en) tx_pulses <= tx_pulses + 1;
        if (rx_fifo_rd_en) rd_pulses <= rd_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic [3:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic write(input logic [3:0] a, input logic [31:0] d);
        drive(1'b1, 1'b1, a, d);
        tick();
        idle();
    endtask

    task automatic read_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'h0);
        tick();
        idle();
        check({tag, "_valid"}, {31'b0, rsp_valid}, 32'h1);
        check(tag, rsp_rdata, exp);
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_mem[rx_wr] = b;
        rx_wr = rx_wr + 4'd1;
    endtask

    initial begin
        rst = 1'b1;
        tx_fifo_full = 1'b0;
        idle();
        tick();
        tick();
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_start_tx", {31'b0, start_tx}, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_strobes", {30'b0, tx_fifo_wr_en, rx_fifo_rd_en}, 32'h0);
        rst = 1'b0;
        tick();

        // 1: two TX pushes
        drive(1'b1, 1'b1, 4'h4, 32'h0000_0041);
        #1;
        check("t1_wr_en0", {31'b0, tx_fifo_wr_en}, 32'h1);
        check("t1_din0", {24'b0, tx_fifo_din}, 32'h41);
        tick();
        drive(1'b1, 1'b1, 4'h4, 32'hFFFF_FF42);
        #1;
        check("t1_wr_en1", {31'b0, tx_fifo_wr_en}, 32'h1);
        check("t1_din1", {24'b0, tx_fifo_din}, 32'h42);
        tick();
        idle();
        #1;
        check("t1_wr_idle", {31'b0, tx_fifo_wr_en}, 32'h0);
        check("t1_pulses", tx_pulses, 32'd2);
        read_chk("t1_status", 4'h0, 32'h0);

        // 2: overflow, then W1C clear
        tx_fifo_full = 1'b1;
        drive(1'b1, 1'b1, 4'h4, 32'h55);
        #1;
        check("t2_no_wr", {31'b0, tx_fifo_wr_en}, 32'h0);
        tick();
        idle();
        read_chk("t2_status_full", 4'h0, 32'h5);
        tx_fifo_full = 1'b0;
        read_chk("t2_status", 4'h0, 32'h4);
        write(4'hC, 32'h100);
        read_chk("t2_status_clr", 4'h0, 32'h0);
        check("t2_pulses", tx_pulses, 32'd2);

        // 3: back-to-back RX pops
        rx_push(8'h3C);
        rx_push(8'h7E);
        read_chk("t3_status", 4'h0, 32'h2);
        drive(1'b1, 1'b0, 4'h8, 32'h0);
        #1;
        check("t3_rd_en0", {31'b0, rx_fifo_rd_en}, 32'h1);
        tick();
        check("t3_rsp0_valid", {31'b0, rsp_valid}, 32'h1);
        check("t3_rsp0", rsp_rdata, 32'h13C);
        check("t3_rd_en1", {31'b0, rx_fifo_rd_en}, 32'h1);
        tick();
        idle();
        check("t3_rsp1_valid", {31'b0, rsp_valid}, 32'h1);
        check("t3_rsp1", rsp_rdata, 32'h17E);
        tick();
        check("t3_rsp_idle", {31'b0, rsp_valid}, 32'h0);
        check("t3_rdata_hold", rsp_rdata, 32'h17E);
        check("t3_pulses", rd_pulses, 32'd2);

        // 4: underflow, W1C, re-underflow; CTRL readback with W1C bits reading 0
        drive(1'b1, 1'b0, 4'h8, 32'h0);
        #1;
        check("t4_no_rd", {31'b0, rx_fifo_rd_en}, 32'h0);
        tick();
        idle();
        check("t4_rsp", rsp_rdata, 32'h0);
        read_chk("t4_status", 4'h0, 32'h8);
        write(4'hC, 32'h200);
        read_chk("t4_status_clr", 4'h0, 32'h0);
        read_chk("t4_unf_again", 4'h8, 32'h0);
        read_chk("t4_status_again", 4'h0, 32'h8);
        write(4'hC, 32'h306);
        read_chk("t4_ctrl", 4'hC, 32'h6);
        read_chk("t4_status_final", 4'h0, 32'h0);
        read_chk("t4_txdata_rd", 4'h4, 32'h0);
        check("t4_pulses", rd_pulses, 32'd2);

        // 5: start_tx and rx irq
        write(4'hC, 32'h0);
        tick();
        check("t5_irq_off", {31'b0, irq}, 32'h0);
        rx_push(8'h11);
        write(4'hC, 32'h3);
        check("t5_start_tx", {31'b0, start_tx}, 32'h1);
        check("t5_irq_lat", {31'b0, irq}, 32'h0);
        tick();
        check("t5_irq_on", {31'b0, irq}, 32'h1);
        read_chk("t5_rx", 4'h8, 32'h111);
        tick();
        check("t5_irq_drain", {31'b0, irq}, 32'h0);

        // 6: reset during an RX read
        rx_push(8'h22);
        drive(1'b1, 1'b0, 4'h8, 32'h0);
        rst = 1'b1;
        #1;
        check("t6_no_rd", {31'b0, rx_fifo_rd_en}, 32'h0);
        tick();
        idle();
        rst = 1'b0;
        check("t6_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("t6_start_tx", {31'b0, start_tx}, 32'h0);
        check("t6_irq", {31'b0, irq}, 32'h0);
        tick();
        check("t6_irq_after", {31'b0, irq}, 32'h0);
        read_chk("t6_status", 4'h0, 32'h2);
        check("t6_pulses", rd_pulses, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
